// File: rtl/mem_arbiter_if.sv
// Cache/RAM bundle seen by the memory arbiter. master = arbiter side, slave = caches + RAM side.
// Port names mirror the cache and RAM pin names so the waveforms read the same on both sides.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// I/D cache to single-port RAM arbiter; grant registered one cycle after the request, held until ACCESS.
// RAM status backpressures via iwait/dwait; a streak counter bounds data starving instruction fetch.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

    state_t        state;
    logic [SW-1:0] dstreak;
    logic          access;
    logic          dreq;
    logic          streak_full;

    assign access      = (bus.ramstate == RAM_ACCESS);
    assign dreq        = bus.dREN | bus.dWEN;
    assign streak_full = (dstreak == SW'(MAX_DSTREAK));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            dstreak <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.iREN && streak_full) state <= ISERV;
                    else if (dreq)               state <= DSERV;
                    else if (bus.iREN)           state <= ISERV;
                end
                ISERV:   if (!bus.iREN || access) state <= IDLE;
                DSERV:   if (!dreq || access)     state <= IDLE;
                default: state <= IDLE;
            endcase

            // Streak only counts data completions that happened while a fetch was waiting.
            if (!bus.iREN)
                dstreak <= '0;
            else if (state == ISERV && access)
                dstreak <= '0;
            else if (state == DSERV && access && dreq && !streak_full)
                dstreak <= dstreak + 1'b1;
        end
    end

    // Waits and loads must react to ramstate in the same cycle, so outputs decode the grant combinationally.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state)
            ISERV: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !access;
                bus.iload   = access ? bus.ramload : '0;
            end
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & !bus.dWEN;
                bus.ramstore = bus.dWEN ? bus.dstore : '0;
                bus.dwait    = !access;
                bus.dload    = (access && !bus.dWEN) ? bus.ramload : '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed corner cases, then random I/D traffic against a RAM model.
module tb_mem_arbiter;
    localparam int MAX_DSTREAK = 4;
    localparam int BOUND       = 200;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] shadow[logic [31:0]];
    bit          auto_ram = 1'b0;
    bit          watch    = 1'b0;
    logic [1:0]  dir_state = 2'd0;
    int          streak   = 0;
    int          lat      = 0;
    bit          busy     = 1'b0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAM model: sole driver of ramstate/ramload; random latency in auto mode, scripted state otherwise.
    initial begin
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (auto_ram) begin
                if (bus.ramREN || bus.ramWEN) begin
                    if (!busy) begin
                        busy = 1'b1;
                        lat  = $urandom_range(0, 3);
                    end
                    if (lat == 0) begin
                        bus.ramstate = ACCESS;
                        busy = 1'b0;
                    end else begin
                        bus.ramstate = 2'($urandom_range(0, 3));
                        if (bus.ramstate == ACCESS) bus.ramstate = BUSY;
                        lat--;
                    end
                end else begin
                    busy = 1'b0;
                    bus.ramstate = FREE;
                end
            end else begin
                bus.ramstate = dir_state;
            end
            bus.ramload = (bus.ramstate == ACCESS) ? ram_rd(bus.ramaddr) : $urandom;
            if (bus.ramWEN && bus.ramstate == ACCESS) mem[bus.ramaddr] = bus.ramstore;
        end
    end

    // Monitor: pops the scoreboard on each completion and checks per-cycle RAM-side rules.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (bus.iwait === 1'b0) begin
                    if (iq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL i_spurious_done: iwait low with no fetch outstanding at %0t", $time);
                    end else check("iload", bus.iload, iq.pop_front());
                end
                if (bus.dwait === 1'b0) begin
                    if (dq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL d_spurious_done: dwait low with no data request outstanding at %0t", $time);
                    end else check("dload", bus.dload, dq.pop_front());
                end
                check1("one_enable", bus.ramREN & bus.ramWEN, 1'b0);
                if (bus.ramWEN) begin
                    check("wr_addr", bus.ramaddr, bus.daddr);
                    check("wr_data", bus.ramstore, bus.dstore);
                end
                if (bus.ramREN)
                    check1("rd_addr_src", (bus.iREN && bus.ramaddr == bus.iaddr) ||
                                          (bus.dREN && bus.ramaddr == bus.daddr), 1'b1);
                if (watch) begin
                    if (!bus.iREN) streak = 0;
                    else begin
                        if ((bus.ramREN || bus.ramWEN) && bus.ramaddr[12])
                            check1("dgrant_while_starved", streak < MAX_DSTREAK, 1'b1);
                        if (bus.dwait === 1'b0 && streak < MAX_DSTREAK) streak++;
                        if (bus.iwait === 1'b0) streak = 0;
                    end
                end
            end
        end
    end

    task automatic icache_run(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            int cnt;
            a = 32'($urandom_range(0, 4095));
            bus.iaddr = a;
            bus.iREN  = 1'b1;
            iq.push_back(ref_rd(a));
            cnt = 0;
            do begin @(negedge CLK); cnt++; end while (bus.iwait !== 1'b0 && cnt < BOUND);
            check1("ifetch_completes", bus.iwait, 1'b0);
            tick();
            bus.iREN = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic dcache_run(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            int op;
            int cnt;
            op = $urandom_range(0, 2);
            a  = 32'h1100 | 32'($urandom_range(0, 31));
            d  = $urandom;
            bus.daddr  = a;
            bus.dstore = d;
            bus.dREN   = (op != 1);
            bus.dWEN   = (op != 0);
            if (op == 0) dq.push_back(ref_rd(a));
            else begin
                dq.push_back(32'h0);
                shadow[a] = d;
            end
            cnt = 0;
            do begin @(negedge CLK); cnt++; end while (bus.dwait !== 1'b0 && cnt < BOUND);
            check1("daccess_completes", bus.dwait, 1'b0);
            tick();
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        bit is_i;
        bit is_d;
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0;
        mem[32'h40]      = 32'h2008_0001; shadow[32'h40]   = 32'h2008_0001;
        mem[32'h1000]    = 32'hDEAD_BEEF; shadow[32'h1000] = 32'hDEAD_BEEF;

        // Outputs held in reset.
        @(negedge CLK);
        check1("rst_iwait", bus.iwait, 1'b1);
        check1("rst_dwait", bus.dwait, 1'b1);
        check1("rst_ren", bus.ramREN, 1'b0);
        check1("rst_wen", bus.ramWEN, 1'b0);
        check("rst_addr", bus.ramaddr, 32'h0);
        check("rst_store", bus.ramstore, 32'h0);
        check("rst_iload", bus.iload, 32'h0);
        check("rst_dload", bus.dload, 32'h0);
        tick(); RST = 1'b0;

        // Lone fetch: BUSY, BUSY, ACCESS.
        bus.iREN = 1'b1; bus.iaddr = 32'h40; dir_state = BUSY;
        iq.push_back(ref_rd(32'h40));
        @(negedge CLK); check1("if_idle_ren", bus.ramREN, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick(); dir_state = (c == 3) ? ACCESS : BUSY;
            @(negedge CLK);
            check1("if_ren", bus.ramREN, 1'b1);
            check("if_addr", bus.ramaddr, 32'h40);
            check1("if_iwait", bus.iwait, c != 3);
        end
        tick(); dir_state = FREE;
        @(negedge CLK);
        check1("if_idle_after", bus.ramREN, 1'b0);
        check1("if_idle_iwait", bus.iwait, 1'b1);

        // Reset pulse in the middle of a fetch.
        tick(); bus.iaddr = 32'h80; dir_state = BUSY;
        @(negedge CLK); check1("rs_ren_before", bus.ramREN, 1'b1);
        #2 RST = 1'b1;
        #1;
        check1("rs_iwait", bus.iwait, 1'b1);
        check1("rs_ren", bus.ramREN, 1'b0);
        check("rs_addr", bus.ramaddr, 32'h0);
        tick(); tick(); RST = 1'b0;
        @(negedge CLK); check1("rs_idle_after", bus.ramREN, 1'b0);
        tick(); bus.iREN = 1'b0;
        tick();

        // Simultaneous I and D: data first, fetch after one IDLE cycle.
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h1000; dir_state = ACCESS;
        dq.push_back(ref_rd(32'h1000));
        iq.push_back(ref_rd(32'h44));
        @(negedge CLK); check1("sim_idle", bus.ramREN, 1'b0);
        tick(); @(negedge CLK);
        check("sim_d_addr", bus.ramaddr, 32'h1000);
        check1("sim_dwait", bus.dwait, 1'b0);
        check1("sim_iwait_held", bus.iwait, 1'b1);
        tick(); bus.dREN = 1'b0; dir_state = FREE;
        @(negedge CLK); check1("sim_gap", bus.ramREN, 1'b0);
        tick(); dir_state = ACCESS;
        @(negedge CLK);
        check("sim_i_addr", bus.ramaddr, 32'h44);
        check1("sim_i_done", bus.iwait, 1'b0);
        tick(); bus.iREN = 1'b0; dir_state = FREE;

        // Write wins over read; then read the word back.
        tick(); bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.dstore = 32'hCAFE_F00D; bus.daddr = 32'h2004; dir_state = BUSY;
        dq.push_back(32'h0); shadow[32'h2004] = 32'hCAFE_F00D;
        tick(); @(negedge CLK);
        check1("wr_wen", bus.ramWEN, 1'b1);
        check1("wr_ren", bus.ramREN, 1'b0);
        check("wr_store", bus.ramstore, 32'hCAFE_F00D);
        check("wr_addr_dir", bus.ramaddr, 32'h2004);
        check1("wr_dwait_busy", bus.dwait, 1'b1);
        tick(); dir_state = ACCESS;
        @(negedge CLK); check1("wr_dwait_done", bus.dwait, 1'b0);
        tick(); bus.dWEN = 1'b0; bus.dstore = '0;
        dq.push_back(ref_rd(32'h2004));
        tick(); @(negedge CLK); check1("rb_done", bus.dwait, 1'b0);
        tick(); bus.dREN = 1'b0; dir_state = FREE;

        // ERROR three cycles, then ACCESS.
        tick(); bus.dREN = 1'b1; bus.daddr = 32'h1008; dir_state = ERROR;
        dq.push_back(ref_rd(32'h1008));
        for (int c = 1; c <= 3; c++) begin
            tick(); @(negedge CLK);
            check1("err_dwait", bus.dwait, 1'b1);
            check1("err_ren", bus.ramREN, 1'b1);
        end
        tick(); dir_state = ACCESS;
        @(negedge CLK); check1("err_done", bus.dwait, 1'b0);
        tick(); bus.dREN = 1'b0; dir_state = FREE;

        // Abort while BUSY: enable drops immediately, nothing completes.
        tick(); bus.dREN = 1'b1; bus.daddr = 32'h100C; dir_state = BUSY;
        tick(); @(negedge CLK); check1("ab_ren", bus.ramREN, 1'b1);
        tick(); bus.dREN = 1'b0;
        @(negedge CLK);
        check1("ab_ren_drop", bus.ramREN, 1'b0);
        check1("ab_dwait", bus.dwait, 1'b1);
        tick(); dir_state = ACCESS;
        @(negedge CLK);
        check1("ab_idle_ren", bus.ramREN, 1'b0);
        check1("ab_idle_dwait", bus.dwait, 1'b1);
        tick(); dir_state = FREE;

        // Starvation bound: every (MAX_DSTREAK+1)-th completion goes to the fetch.
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.daddr = 32'h1010; dir_state = ACCESS;
        for (int k = 0; k < 10; k++) begin
            if (k % (MAX_DSTREAK + 1) == MAX_DSTREAK) iq.push_back(ref_rd(32'h48));
            else dq.push_back(ref_rd(32'h1010));
        end
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            @(negedge CLK);
            is_i = (c % 2 == 1) && (((c - 1) / 2) % (MAX_DSTREAK + 1) == MAX_DSTREAK);
            is_d = (c % 2 == 1) && !is_i;
            check1("strv_iwait", bus.iwait, !is_i);
            check1("strv_dwait", bus.dwait, !is_d);
        end
        tick(); bus.iREN = 1'b0; bus.dREN = 1'b0; dir_state = FREE;

        // Random concurrent traffic.
        tick(); auto_ram = 1'b1; watch = 1'b1; streak = 0;
        fork
            icache_run(80);
            dcache_run(80);
        join
        repeat (3) tick();
        check("iq_drained", 32'(iq.size()), 32'h0);
        check("dq_drained", 32'(dq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-CPU memory controller that sits directly downstream of the instruction cache and data cache. It arbitrates their miss/writeback requests onto the single-ported RAM and returns wait/load handshakes to each cache. Grants are registered and held until the RAM completes the access. A streak counter bounds how long data traffic can starve instruction fetch.

Parameters:
MAX_DSTREAK, 4, consecutive completed data transactions allowed while iREN is pending before instruction gets priority (must be >=1)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
iREN  input  1  icache read request
iaddr  input  32  icache request address
dREN  input  1  dcache read request
dWEN  input  1  dcache write request
daddr  input  32  dcache request address
dstore  input  32  dcache write data
iwait  output  1  high = icache request not yet complete
iload  output  32  instruction data, valid when iwait low
dwait  output  1  high = dcache request not yet complete
dload  output  32  data read result, valid when dwait low and dREN
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- State register values: IDLE, ISERV, DSERV. Streak counter dstreak has width clog2(MAX_DSTREAK+1).
- Reset (RST high, async): state=IDLE, dstreak=0. Outputs while in reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- IDLE outputs: iwait=1, dwait=1, RAM enables 0, ramaddr=0, ramstore=0, loads 0.
- IDLE next state, evaluated in priority order:
  - iREN && dstreak==MAX_DSTREAK -> ISERV.
  - else dREN|dWEN -> DSERV.
  - else iREN -> ISERV.
  - else stay in IDLE.
- Grant latency: a request seen in IDLE at cycle N is presented to the RAM in cycle N+1. Minimum completion is therefore cycle N+1, when ramstate=ACCESS arrives in that same cycle.
- ISERV outputs:
  - ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - iwait = !(ramstate==ACCESS).
  - iload = ramload when ramstate==ACCESS, else 0.
  - dwait=1, dload=0.
- DSERV outputs:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. Write wins when dREN and dWEN are both high.
  - Else: ramREN=1, ramWEN=0, ramstore=0.
  - dwait = !(ramstate==ACCESS).
  - dload = ramload when ramstate==ACCESS and !dWEN, else 0.
  - iwait=1, iload=0.
- Completion: ramstate==ACCESS in a SERV state -> IDLE next edge. Exactly one cycle of wait low per transaction. Back-to-back requests each pay one IDLE cycle.
- FREE/BUSY in a SERV state: hold state and keep driving the request.
- ERROR in a SERV state: treated as not complete. Wait stays high and the request is re-driven every cycle until ACCESS.
- Requester withdraws mid-service (iREN low in ISERV, or dREN|dWEN low in DSERV): next state IDLE, no completion. RAM enables follow the live request signals, so they drop the same cycle.
- dstreak update on each edge:
  - DSERV completes with iREN high -> dstreak+1, saturating at MAX_DSTREAK.
  - ISERV completes -> 0.
  - iREN low in any cycle -> 0.
  - Otherwise hold.
- Addresses and data pass through unmodified. No alignment checks; address bits [1:0] are forwarded as-is.
- Only one RAM enable is ever high in a cycle. Neither enable is high in IDLE.

Test Plan:
- Reset mid-ISERV: RST pulsed while ramstate=BUSY -> same cycle iwait=1, ramREN=0, ramaddr=0; after release, state IDLE and dstreak=0.
- Lone ifetch: iREN=1, iaddr=0x0000_0040, ramstate=BUSY two cycles then ACCESS with ramload=0x2008_0001 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait low exactly in the ACCESS cycle with iload=0x2008_0001; IDLE next cycle.
- Simultaneous requests: iREN=1 and dREN=1, daddr=0x0000_1000, ramload=0xDEAD_BEEF -> DSERV first, with dload=0xDEAD_BEEF and iwait held high; ISERV follows after one IDLE cycle.
- Write priority: dREN=1, dWEN=1, dstore=0xCAFE_F00D, daddr=0x0000_2004 -> ramWEN=1, ramREN=0, ramstore=0xCAFE_F00D; dwait drops on ACCESS; dload=0.
- Starvation bound: iREN held high, data requests issued continuously, MAX_DSTREAK=4 -> exactly 4 data completions, then an ISERV grant even though dREN is high; dstreak returns to 0 after the ifetch completes.
- ERROR and abort: ramstate=ERROR for 3 cycles then ACCESS -> dwait stays high through ERROR with the request re-driven; completes on ACCESS. In a separate run, drop dREN while BUSY -> ramREN=0 the same cycle, IDLE next cycle, dwait never goes low.
